// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Imported by pc_next_sel and pc_fetch_sequencer.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_RSP = 2'd2,
    HOLD     = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C       = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC      = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR   = 32'h0000_0100;

  function automatic logic [31:0] pc_plus4(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > redirect > pending > sequential.
// Misaligned redirects become traps; a branch never displaces a pending trap.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic        trap_req_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_tgt_i,
  input  logic        pend_valid_i,
  input  logic        pend_trap_i,
  input  logic [31:0] pend_tgt_i,
  input  logic [31:0] seq_pc_i,
  output logic        event_o,
  output logic        misalign_o,
  output logic [31:0] next_pc_o,
  output logic        next_trap_o
);

  logic take_trap;
  logic take_br;
  logic take_pend;

  assign misalign_o = redir_valid_i && !trap_req_i
                      && (redir_tgt_i[1:0] != 2'b00);
  assign event_o    = trap_req_i || redir_valid_i;

  assign take_trap = trap_req_i || misalign_o;
  assign take_br   = redir_valid_i && !take_trap
                     && !(pend_valid_i && pend_trap_i);
  assign take_pend = pend_valid_i && !take_trap && !take_br;

  always_comb begin
    next_pc_o   = seq_pc_i;
    next_trap_o = 1'b0;
    unique case (1'b1)
      take_trap: begin
        next_pc_o   = TRAP_VECTOR;
        next_trap_o = 1'b1;
      end
      take_br: begin
        next_pc_o   = redir_tgt_i;
        next_trap_o = 1'b0;
      end
      take_pend: begin
        next_pc_o   = pend_tgt_i;
        next_trap_o = pend_trap_i;
      end
      default: begin
        next_pc_o   = seq_pc_i;
        next_trap_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: owns the PC, issues one imem request at a time,
// holds the fetched instruction for decode and drops stale responses.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_C
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        Trap_Req,
  input  logic        Stall,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Gnt,
  input  logic        Imem_Rvalid,
  input  logic [31:0] Imem_Rdata,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic [31:0] Instr_PC_Plus4,
  output logic        Misalign_Err
);

  fetch_state_e state_q, state_d;

  logic        req_q,   req_d;
  logic [31:0] addr_q,  addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q,   ipc_d;
  logic [31:0] ipc4_q,  ipc4_d;
  logic        mis_q,   mis_d;
  logic        kill_q,  kill_d;
  logic        ptrap_q, ptrap_d;
  logic [31:0] ptgt_q,  ptgt_d;

  logic [31:0] seq_pc;
  logic        ev;
  logic        misalign;
  logic [31:0] sel_pc;
  logic        sel_trap;

  always_comb begin
    seq_pc = addr_q;
    if (state_q == HOLD) begin
      seq_pc = ipc4_q;
    end else if (state_q == IDLE) begin
      seq_pc = RESET_PC;
    end
  end

  // kill_q doubles as the pending-target valid flag
  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_sel (
    .trap_req_i    (Trap_Req),
    .redir_valid_i (Redirect_Valid),
    .redir_tgt_i   (Redirect_Target),
    .pend_valid_i  (kill_q),
    .pend_trap_i   (ptrap_q),
    .pend_tgt_i    (ptgt_q),
    .seq_pc_i      (seq_pc),
    .event_o       (ev),
    .misalign_o    (misalign),
    .next_pc_o     (sel_pc),
    .next_trap_o   (sel_trap)
  );

  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      ipc4_q  <= pc_plus4(RESET_PC);
      mis_q   <= 1'b0;
      kill_q  <= 1'b0;
      ptrap_q <= 1'b0;
      ptgt_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      mis_q   <= mis_d;
      kill_q  <= kill_d;
      ptrap_q <= ptrap_d;
      ptgt_q  <= ptgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (Imem_Gnt) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (Imem_Rvalid) begin
          state_d = (kill_q || ev) ? FETCH : HOLD;
        end
      end
      HOLD: begin
        if (ev || !Stall) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    mis_d   = misalign;
    kill_d  = kill_q;
    ptrap_d = ptrap_q;
    ptgt_d  = ptgt_q;
    unique case (state_q)
      IDLE: begin
        req_d  = 1'b1;
        addr_d = sel_pc;
      end
      FETCH: begin
        if (Imem_Gnt) begin
          req_d = 1'b0;
        end
        if (ev) begin
          kill_d  = 1'b1;
          ptgt_d  = sel_pc;
          ptrap_d = sel_trap;
        end
      end
      WAIT_RSP: begin
        if (Imem_Rvalid) begin
          if (kill_q || ev) begin
            req_d   = 1'b1;
            addr_d  = sel_pc;
            kill_d  = 1'b0;
            ptrap_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            instr_d = Imem_Rdata;
            ipc_d   = addr_q;
            ipc4_d  = pc_plus4(addr_q);
          end
        end else if (ev) begin
          kill_d  = 1'b1;
          ptgt_d  = sel_pc;
          ptrap_d = sel_trap;
        end
      end
      HOLD: begin
        if (ev || !Stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          req_d   = 1'b1;
          addr_d  = sel_pc;
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  assign Imem_Req       = req_q;
  assign Imem_Addr      = addr_q;
  assign Instr_Valid    = valid_q;
  assign Instr          = instr_q;
  assign Instr_PC       = ipc_q;
  assign Instr_PC_Plus4 = ipc4_q;
  assign Misalign_Err   = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: random imem timing,
// redirects, traps and stalls against a program-order reference model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TV     = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        Clk_Core;
  logic        Rst_Core;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Trap_Req;
  logic        Stall;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Gnt;
  logic        Imem_Rvalid;
  logic [31:0] Imem_Rdata;
  logic        Instr_Valid;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic [31:0] Instr_PC_Plus4;
  logic        Misalign_Err;

  pc_fetch_sequencer #(
    .RESET_PC    (RST_PC),
    .TRAP_VECTOR (TV),
    .NOP_INSTR   (NOP)
  ) dut (
    .Clk_Core        (Clk_Core),
    .Rst_Core        (Rst_Core),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .Trap_Req        (Trap_Req),
    .Stall           (Stall),
    .Imem_Req        (Imem_Req),
    .Imem_Addr       (Imem_Addr),
    .Imem_Gnt        (Imem_Gnt),
    .Imem_Rvalid     (Imem_Rvalid),
    .Imem_Rdata      (Imem_Rdata),
    .Instr_Valid     (Instr_Valid),
    .Instr           (Instr),
    .Instr_PC        (Instr_PC),
    .Instr_PC_Plus4  (Instr_PC_Plus4),
    .Misalign_Err    (Misalign_Err)
  );

  initial Clk_Core = 1'b0;
  always #5 Clk_Core = ~Clk_Core;

  int checks = 0;
  int failures = 0;

  // model: next program-order fetch address and in-flight fetch
  logic [31:0] exp_addr_q[$];
  logic [31:0] dlv_q[$];
  bit          trap_lock;
  bit          mis_exp;
  bit          last_stall;
  bit          last_ev;
  bit          mon_en;
  logic        prev_req;
  logic        prev_valid;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;

  // imem responder
  bit          outstanding;
  int          lat_cnt;
  logic [31:0] out_addr;
  int          gnt_pct;
  int          max_lat;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req", 32'(Imem_Req), 32'd0);
    chk("rst_addr", Imem_Addr, RST_PC);
    chk("rst_valid", 32'(Instr_Valid), 32'd0);
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", Instr_PC, RST_PC);
    chk("rst_pc4", Instr_PC_Plus4, RST_PC + 32'd4);
    chk("rst_mis", 32'(Misalign_Err), 32'd0);
  endtask

  always @(posedge Clk_Core) begin
    logic [31:0] a;
    #1;
    if (mon_en && !Rst_Core) begin
      chk("misalign", 32'(Misalign_Err), 32'(mis_exp));
      if (Instr_Valid) chk("req_in_hold", 32'(Imem_Req), 32'd0);
      if (Imem_Req && !prev_req) begin
        chk("req_expected", 32'(exp_addr_q.size()), 32'd1);
        if (exp_addr_q.size() > 0) begin
          a = exp_addr_q.pop_front();
          chk("fetch_addr", Imem_Addr, a);
          dlv_q.push_back(a);
        end
        trap_lock = 1'b0;
      end
      if (Instr_Valid && !prev_valid) begin
        chk("dlv_expected", 32'(dlv_q.size()), 32'd1);
        if (dlv_q.size() > 0) begin
          a = dlv_q.pop_front();
          chk("instr_pc", Instr_PC, a);
          chk("instr", Instr, mem(a));
          chk("instr_pc4", Instr_PC_Plus4, a + 32'd4);
          exp_addr_q.push_back(a + 32'd4);
        end
      end
      if (prev_valid && last_stall && !last_ev) begin
        chk("stall_valid", 32'(Instr_Valid), 32'd1);
        chk("stall_instr", Instr, prev_instr);
        chk("stall_pc", Instr_PC, prev_pc);
      end
    end
    prev_req   = Imem_Req;
    prev_valid = Instr_Valid;
    prev_instr = Instr;
    prev_pc    = Instr_PC;
  end

  task automatic model_event(input bit rv, input logic [31:0] tgt,
                             input bit tr);
    bit is_trap;
    is_trap = tr || (rv && (tgt[1:0] != 2'b00));
    dlv_q.delete();
    if (is_trap || !trap_lock) begin
      exp_addr_q.delete();
      exp_addr_q.push_back(is_trap ? TV : tgt);
    end
    if (is_trap) trap_lock = 1'b1;
  endtask

  // drive one cycle of inputs, then advance to posedge+2
  task automatic drive(input bit rv, input logic [31:0] tgt,
                       input bit tr, input bit st);
    Imem_Gnt    = 1'b0;
    Imem_Rvalid = 1'b0;
    Imem_Rdata  = $urandom;
    if (outstanding) begin
      if (lat_cnt == 0) begin
        Imem_Rvalid = 1'b1;
        Imem_Rdata  = mem(out_addr);
        outstanding = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (Imem_Req && ($urandom_range(0, 99) < gnt_pct)) begin
      Imem_Gnt    = 1'b1;
      outstanding = 1'b1;
      out_addr    = Imem_Addr;
      lat_cnt     = $urandom_range(1, max_lat) - 1;
    end
    if (rv || tr) model_event(rv, tgt, tr);
    mis_exp         = rv && !tr && (tgt[1:0] != 2'b00);
    last_stall      = st;
    last_ev         = rv || tr;
    Redirect_Valid  = rv;
    Redirect_Target = tgt;
    Trap_Req        = tr;
    Stall           = st;
    @(posedge Clk_Core);
    #2;
  endtask

  task automatic wait_valid(input int n);
    int k;
    k = 0;
    while (!Instr_Valid && k < n) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      k++;
    end
    chk("wait_valid", 32'(Instr_Valid), 32'd1);
  endtask

  task automatic wait_rsp_state(input int n);
    int k;
    k = 0;
    while (!(outstanding && !Imem_Req) && k < n) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      k++;
    end
    chk("wait_rsp", 32'(outstanding && !Imem_Req), 32'd1);
  endtask

  task automatic release_reset();
    @(posedge Clk_Core);
    #2;
    exp_addr_q.delete();
    dlv_q.delete();
    exp_addr_q.push_back(RST_PC);
    trap_lock   = 1'b0;
    mis_exp     = 1'b0;
    last_ev     = 1'b0;
    last_stall  = 1'b0;
    outstanding = 1'b0;
    Imem_Rvalid = 1'b0;
    Rst_Core    = 1'b0;
    mon_en      = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit rv, tr, st;
    logic [31:0] tgt;
    Rst_Core = 1'b1;
    Redirect_Valid = 1'b0;
    Redirect_Target = 32'h0;
    Trap_Req = 1'b0;
    Stall = 1'b0;
    Imem_Gnt = 1'b0;
    Imem_Rvalid = 1'b0;
    Imem_Rdata = 32'h0;
    mon_en = 1'b0;
    outstanding = 1'b0;
    gnt_pct = 100;
    max_lat = 1;
    repeat (2) @(posedge Clk_Core);
    #1;
    chk_reset();
    release_reset();

    wait_valid(20);
    chk("t1_instr", Instr, 32'h0050_0093);
    chk("t1_pc", Instr_PC, 32'h0);
    chk("t1_pc4", Instr_PC_Plus4, 32'h4);
    repeat (5) drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t2_req", 32'(Imem_Req), 32'd1);
    chk("t2_addr", Imem_Addr, 32'h4);

    max_lat = 4;
    wait_valid(20);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    wait_rsp_state(20);
    drive(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    chk("t3_drop", 32'(Instr_Valid), 32'd0);
    wait_valid(30);
    chk("t3_pc", Instr_PC, 32'h200);

    drive(1'b1, 32'h0000_0080, 1'b1, 1'b0);
    chk("t4_addr", Imem_Addr, TV);
    wait_valid(30);
    chk("t4_pc", Instr_PC, TV);

    drive(1'b1, 32'h0000_0202, 1'b0, 1'b1);
    chk("t5_mis", 32'(Misalign_Err), 32'd1);
    chk("t5_valid", 32'(Instr_Valid), 32'd0);
    chk("t5_addr", Imem_Addr, TV);
    chk("t5_instr", Instr, NOP);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_mis_pulse", 32'(Misalign_Err), 32'd0);
    wait_valid(30);

    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    wait_valid(30);
    chk("t6_pc", Instr_PC, 32'hFFFF_FFFC);
    chk("t6_pc4", Instr_PC_Plus4, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_addr", Imem_Addr, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      gnt_pct = $urandom_range(30, 100);
      r   = $urandom_range(0, 99);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      rv  = (r < 6) || (r >= 9 && r < 11);
      tr  = (r >= 6 && r < 11);
      st  = ($urandom_range(0, 99) < 40);
      drive(rv, tgt, tr, st);
    end

    wait_rsp_state(40);
    Rst_Core = 1'b1;
    mon_en = 1'b0;
    #1;
    chk_reset();
    Imem_Rvalid = 1'b1;
    Imem_Rdata = 32'hBAD0_BAD0;
    repeat (2) @(posedge Clk_Core);
    #1;
    chk_reset();
    release_reset();
    wait_valid(30);
    chk("t7_pc", Instr_PC, RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch-side controller for the multi-cycle core. Owns the architectural PC and sequences one instruction-memory request at a time over a req/gnt/rvalid handshake. Arbitrates next-PC sources (trap > redirect > pending redirect > PC+4) and presents the fetched instruction to decode with a valid/stall handshake. Discards stale responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
TRAP_VECTOR, 32'h0000_0100, target on Trap_Req or misaligned redirect
NOP_INSTR, 32'h0000_0013, Instr value when no instruction is held (addi x0,x0,0)

Ports:
Clk_Core  in  1  core clock, rising edge
Rst_Core  in  1  asynchronous, active-high reset
Redirect_Valid  in  1  branch/jump taken, 1-cycle pulse
Redirect_Target  in  32  redirect address
Trap_Req  in  1  trap request, 1-cycle pulse
Stall  in  1  decode cannot accept held instruction
Imem_Req  out  1  fetch request
Imem_Addr  out  32  fetch address, stable while Imem_Req && !Imem_Gnt
Imem_Gnt  in  1  request accepted this cycle
Imem_Rvalid  in  1  response valid (earliest cycle after Gnt)
Imem_Rdata  in  32  response data
Instr_Valid  out  1  Instr/Instr_PC valid for decode
Instr  out  32  held instruction
Instr_PC  out  32  address of Instr
Instr_PC_Plus4  out  32  Instr_PC + 4, mod 2^32
Misalign_Err  out  1  1-cycle pulse, redirect target bits[1:0] != 0

Behaviour:
- Reset (async, active-high): state=IDLE; Imem_Req=0; Imem_Addr=RESET_PC; Instr_Valid=0; Instr=NOP_INSTR; Instr_PC=RESET_PC; Instr_PC_Plus4=RESET_PC+4; Misalign_Err=0; kill=0; pending=0. Asserting reset mid-transaction abandons it; responses arriving during or after reset with no request outstanding are ignored.
- All outputs are registered. At most one request is outstanding.
- IDLE: one cycle after reset release -> FETCH, Imem_Req=1, Imem_Addr=RESET_PC.
- FETCH: Imem_Req=1. On Gnt -> WAIT_RSP with Imem_Req=0 next cycle. Address never changes before Gnt.
- WAIT_RSP: on Rvalid with kill=0 -> HOLD; Instr<=Rdata, Instr_PC<=Imem_Addr, Instr_Valid=1 the next cycle. On Rvalid with kill=1 -> drop data, clear kill, -> FETCH at pending target.
- HOLD: Instr_Valid=1. If !Stall, the instruction is consumed: Instr_Valid=0 next cycle, -> FETCH at Instr_PC+4. If Stall, all Instr* outputs are held.
- Redirect/trap sources: Trap_Req beats Redirect_Valid when both arrive in the same cycle. A redirect with Redirect_Target[1:0]!=0 is converted to a trap to TRAP_VECTOR, with Misalign_Err=1 the next cycle.
- Redirect/trap in HOLD: consumes the held instruction regardless of Stall. Next cycle: Instr_Valid=0, Instr=NOP_INSTR, FETCH at target.
- Redirect/trap in FETCH before or with Gnt: latch the pending target and set kill. On Gnt the original address is still issued. Its response is dropped, then FETCH at the pending target.
- Redirect/trap in WAIT_RSP: latch pending, set kill. If it coincides with Rvalid, that response is dropped.
- A later redirect overwrites pending, except that a branch never overwrites a pending trap.
- Redirect in IDLE replaces RESET_PC as the first fetch address.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.

Decomposition:
- Package pc_fetch_pkg: state enum {IDLE, FETCH, WAIT_RSP, HOLD}, NOP constant, default RESET_PC and TRAP_VECTOR.
- One combinational sub-module, pc_next_sel: priority mux over trap, redirect, pending and PC+4, plus the misalignment check.

Test Plan:
- Reset release, Gnt same cycle, Rvalid +1 with Rdata=32'h00500093 -> Imem_Addr=0; Instr_Valid=1 with Instr=32'h00500093, Instr_PC=0, Instr_PC_Plus4=4; next fetch address 4.
- Stall=1 for 5 cycles in HOLD -> Instr/Instr_PC stable and Imem_Req=0 throughout; Stall release -> Imem_Addr=Instr_PC+4 the next cycle.
- Redirect_Target=32'h0000_0200 during WAIT_RSP -> that response dropped (Instr_Valid stays 0), then Imem_Addr=32'h200.
- Trap_Req and Redirect_Valid (target 32'h80) in the same cycle -> Imem_Addr=TRAP_VECTOR=32'h100.
- Redirect_Target=32'h0000_0202 in HOLD -> Misalign_Err pulses for 1 cycle, Imem_Addr=32'h100, Instr_Valid=0.
- Redirect to 32'hFFFF_FFFC, consume with Stall=0 -> next Imem_Addr=32'h0000_0000; async reset asserted mid-WAIT_RSP -> all outputs return to reset values immediately.
